// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: six-phase T-state sequencer and control decoder for
// the 8-bit computer. Decodes opcode, flags and the halt latch into one-hot
// control lines for the shared bus.
// Optional feature: SAP_EARLY_END_EN -- return to T0 right after an
// instruction's last active phase instead of always running T0..T5.
module sap_control_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic [2:0] t_state,
  output logic       pc_en,
  output logic       pc_out,
  output logic       jmp,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       halt
);

  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
  } tstate_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;
  logic    jump_taken;
  tstate_e last_phase;

  assign t_state = state_q;

  // Conditional/unconditional jump resolution, sampled with current flags
  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = carry_flag;
      OP_JZ:   jump_taken = zero_flag;
      default: jump_taken = 1'b0;
    endcase
  end

  // Last phase that carries any control activity for the current opcode
  always_comb begin
    last_phase = T2;
    case (opcode)
      OP_LDA, OP_STA:                  last_phase = T4;
      OP_ADD, OP_SUB:                  last_phase = T5;
      OP_LDI, OP_JMP, OP_OUT, OP_HLT:  last_phase = T3;
      OP_JC, OP_JZ:                    last_phase = jump_taken ? T3 : T2;
      default:                         last_phase = T2;
    endcase
  end

  // Next T-state and halt latch; HLT in T3 freezes the counter at T3
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (state_q == T3 && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end else if (state_q == T5) begin
        state_d = T0;
`ifdef SAP_EARLY_END_EN
      end else if (state_q == last_phase) begin
        state_d = T0;
`endif
      end else begin
        case (state_q)
          T0:      state_d = T1;
          T1:      state_d = T2;
          T2:      state_d = T3;
          T3:      state_d = T4;
          T4:      state_d = T5;
          default: state_d = T0;
        endcase
      end
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Control-line decode of phase, opcode, flags and halt latch
  always_comb begin
    pc_en    = 1'b0;
    pc_out   = 1'b0;
    jmp      = 1'b0;
    mar_in   = 1'b0;
    ram_out  = 1'b0;
    ram_in   = 1'b0;
    ir_in    = 1'b0;
    ir_out   = 1'b0;
    a_in     = 1'b0;
    a_out    = 1'b0;
    b_in     = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    flags_in = 1'b0;
    out_in   = 1'b0;
    halt     = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (state_q)
        T0: begin pc_out = 1'b1; mar_in = 1'b1; end
        T1: begin ram_out = 1'b1; ir_in = 1'b1; end
        T2: pc_en = 1'b1;
        T3: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ir_out = 1'b1; mar_in = 1'b1; end
            OP_LDI: begin ir_out = 1'b1; a_in = 1'b1; end
            OP_JMP, OP_JC, OP_JZ: begin ir_out = jump_taken; jmp = jump_taken; end
            OP_OUT: begin a_out = 1'b1; out_in = 1'b1; end
            OP_HLT: halt = 1'b1;
            default: ;
          endcase
        end
        T4: begin
          case (opcode)
            OP_LDA:         begin ram_out = 1'b1; a_in = 1'b1; end
            OP_ADD, OP_SUB: begin ram_out = 1'b1; b_in = 1'b1; end
            OP_STA:         begin a_out = 1'b1; ram_in = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out  = 1'b1;
            a_in     = 1'b1;
            flags_in = 1'b1;
            alu_sub  = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Microprogrammed control sequencer for the 8-bit computer. It steps a six-phase T-state counter and decodes the 4-bit opcode from the instruction register and the carry/zero flags into one-hot control lines. These lines drive the program counter (`pc_en`, `jmp`, `pc_out`), MAR, RAM, IR, A/B registers, ALU, flags and output register. It is the only block that sequences the shared 8-bit bus.

## Interface
No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high; clears T-state and halt latch
- `opcode`  in  4  upper nibble of IR; sampled combinationally in T3–T5
- `carry_flag`  in  1  registered carry from the flags register
- `zero_flag`  in  1  registered zero from the flags register
- `t_state`  out  3  current phase, 0–5
- `pc_en`, `pc_out`, `jmp`  out  1 each  PC increment, PC drives bus, PC loads bus[3:0]
- `mar_in`, `ram_out`, `ram_in`  out  1 each  memory address/data controls
- `ir_in`, `ir_out`  out  1 each  IR load, IR operand nibble drives bus
- `a_in`, `a_out`, `b_in`  out  1 each  register controls
- `alu_out`, `alu_sub`, `flags_in`  out  1 each  ALU drives bus, subtract select, flags load
- `out_in`  out  1  output register load
- `halt`  out  1  halted indicator; gates the clock-enable of downstream registers

## Operation
- T-state counter: 0→1→2→3→4→5→0, advancing every rising edge while not halted.
- Control outputs are a pure combinational decode of (`t_state`, `opcode`, flags, halted latch). Unlisted outputs are 0.
- Fetch, regardless of opcode:
  - T0: `pc_out`, `mar_in`
  - T1: `ram_out`, `ir_in`
  - T2: `pc_en`
- Execute phases T3/T4/T5:
  - 0x0 NOP: –/–/–
  - 0x1 LDA: `ir_out`+`mar_in` / `ram_out`+`a_in` / –
  - 0x2 ADD: `ir_out`+`mar_in` / `ram_out`+`b_in` / `alu_out`+`a_in`+`flags_in`
  - 0x3 SUB: as ADD, plus `alu_sub` in T5 only
  - 0x4 STA: `ir_out`+`mar_in` / `a_out`+`ram_in` / –
  - 0x5 LDI: `ir_out`+`a_in` / – / –
  - 0x6 JMP: `ir_out`+`jmp` / – / –
  - 0x7 JC: `ir_out`+`jmp` only if `carry_flag`=1
  - 0x8 JZ: `ir_out`+`jmp` only if `zero_flag`=1
  - 0xE OUT: `a_out`+`out_in` / – / –
  - 0xF HLT: `halt` in T3
  - 0x9–0xD: treated as NOP
- Not-taken JC/JZ behaves as NOP.
- Halt latch: set on the rising edge ending a T3 with opcode 0xF.
  - While set: `t_state` frozen at 3, `halt`=1, every other control output 0.
  - Only `reset` clears it.
- `pc_en` and `jmp` are never asserted in the same cycle.
- No bus-out pair (`pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out`) is ever asserted in the same cycle.

## Timing
- Reset, asynchronous: `t_state`=0, halt latch=0. Outputs are therefore `pc_out`=1, `mar_in`=1, all others 0, held until the first edge after reset deasserts.
- Reset mid-instruction aborts it immediately; the next cycle is fetch T0.
- Instruction latency without early end: 6 cycles for every opcode.
- Flags for JC/JZ are sampled in T3. A flags update at T5 of the preceding ADD/SUB is visible to the next instruction's T3.
- `opcode` must be stable from the end of T1 until T0 of the next instruction; the IR guarantees this.

## Configuration
- `SAP_EARLY_END_EN` defined: the counter returns to T0 on the edge after an instruction's last active phase. Cycles per instruction:
  - NOP, 0x9–0xD, not-taken JC/JZ: 3
  - LDI, JMP, taken JC/JZ, OUT: 4
  - LDA, STA: 5
  - ADD, SUB: 6
- `SAP_EARLY_END_EN` undefined: every instruction runs the full T0–T5. Idle phases emit all-zero controls.
- Halt behaviour is identical in both builds.

## Test plan
- Reset asserted mid-T4 of ADD → same-cycle `t_state`=0, `pc_out`=`mar_in`=1; halt latch 0.
- opcode=0x2 held, flags 0 → T0..T5 control pattern exactly as tabulated; `alu_sub`=0 throughout; with opcode 0x3, `alu_sub`=1 in T5 only.
- opcode=0x7, `carry_flag`=0 then 1 → T3 `jmp`=0 then `jmp`=1 with `ir_out`=1; `pc_en`=1 only in T2 in both cases.
- opcode=0xF → `halt`=1 in T3; after 10 further clocks `t_state`=3, `halt`=1, all other outputs 0; reset → T0.
- With `SAP_EARLY_END_EN`: sequence NOP, LDI, LDA, ADD → `t_state` returns to 0 after 3, 4, 5, 6 cycles respectively (18 cycles total); without the macro, 24 cycles.
- Random opcode/flag stream over 10k cycles → no cycle has more than one bus-out line high, and never `pc_en`&`jmp`.
